// File: rtl/spi_master.sv
// SPI master, mode 0 (CPOL=0/CPHA=0), one WIDTH-bit full-duplex frame per start; MSB first unless SPI_MASTER_LSB_FIRST_EN.
// Latency: done pulses CLK_DIV*(2*WIDTH+2) clks after the accepting edge. Backpressure: start ignored while busy, no queueing.
module spi_master #(
   parameter int CLK_DIV = 4,
   parameter int WIDTH   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] din,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] dout,
   output logic             ss,
   output logic             sck,
   output logic             mosi,
   input  logic             miso
);
   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

   state_t           state;
   logic [PW-1:0]    phase;
   logic [BW-1:0]    bit_cnt;
   logic [WIDTH-1:0] tx_sr;
   logic [WIDTH-1:0] rx_sr;
   logic [WIDTH-1:0] tx_next;
   logic [WIDTH-1:0] rx_next;
   logic             phase_end;

   assign phase_end = (phase == PH_LAST);

   // mosi is taken straight from the transmit register, so clearing tx_sr idles mosi low
`ifdef SPI_MASTER_LSB_FIRST_EN
   assign mosi    = tx_sr[0];
   assign tx_next = {1'b0, tx_sr[WIDTH-1:1]};
   assign rx_next = {miso, rx_sr[WIDTH-1:1]};
`else
   assign mosi    = tx_sr[WIDTH-1];
   assign tx_next = {tx_sr[WIDTH-2:0], 1'b0};
   assign rx_next = {rx_sr[WIDTH-2:0], miso};
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         phase   <= '0;
         bit_cnt <= '0;
         tx_sr   <= '0;
         rx_sr   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         dout    <= '0;
         ss      <= 1'b1;
         sck     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  tx_sr <= din;
                  ss    <= 1'b0;
                  busy  <= 1'b1;
                  phase <= '0;
                  state <= SETUP;
               end
            end
            SETUP: begin
               if (phase_end) begin
                  phase   <= '0;
                  sck     <= 1'b1;
                  rx_sr   <= rx_next;
                  bit_cnt <= '0;
                  state   <= SHIFT;
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            SHIFT: begin
               if (phase_end) begin
                  phase <= '0;
                  if (sck) begin
                     sck <= 1'b0;
                     if (bit_cnt != BIT_LAST) tx_sr <= tx_next;
                  end else if (bit_cnt == BIT_LAST) begin
                     // final low half-period has elapsed
                     state <= HOLD;
                  end else begin
                     sck     <= 1'b1;
                     rx_sr   <= rx_next;
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            HOLD: begin
               if (phase_end) begin
                  phase <= '0;
                  ss    <= 1'b1;
                  tx_sr <= '0;
                  dout  <= rx_sr;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: loopback frames, behavioural mode-0 slave, busy/start rules, async reset.
module tb_spi_master;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [7:0] din = 8'h00;
   logic       busy, done, ss, sck, mosi, miso;
   logic [7:0] dout;

   logic       loop = 1'b1;
   logic [7:0] slave_din = 8'h00;
   logic [7:0] s_rx = 8'h00;
   logic [7:0] mosi_bits = 8'h00;
   int         rises = 0;
   int         falls = 0;
   int         base_f = 0;
   int         ss_low = 0;
   int         sck_hi = 0;
   int         s_idx;
   logic       s_miso;

   int errors = 0;
   int checks = 0;

   spi_master #(.CLK_DIV(4), .WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .din(din),
      .busy(busy), .done(done), .dout(dout),
      .ss(ss), .sck(sck), .mosi(mosi), .miso(miso)
   );

   always #5 clk = ~clk;

   // mode-0 slave model: first bit out on ss fall, next bit after each sck fall
   always @(negedge ss) base_f = falls;
   always @(negedge sck) falls = falls + 1;
   always @(posedge sck) begin
      rises     = rises + 1;
      mosi_bits = {mosi_bits[6:0], mosi};
      s_rx      = {s_rx[6:0], mosi};
   end
   always_comb begin
      s_idx  = falls - base_f;
      s_miso = 1'b0;
      if (s_idx >= 0 && s_idx < 8) s_miso = slave_din[3'(7 - s_idx)];
   end
   assign miso = loop ? mosi : s_miso;

   always @(negedge clk) begin
      if (!ss) ss_low = ss_low + 1;
      if (sck) sck_hi = sck_hi + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // one frame; optionally pokes start/din=FF mid-frame; lat = clks from accept edge to done cycle
   task automatic run_frame(input logic [7:0] d, input bit poke, output int lat,
                            output logic first_mosi, output int d_ss, output int d_hi, output int d_rise);
      int ss0, hi0, r0;
      @(negedge clk);
      ss0 = ss_low; hi0 = sck_hi; r0 = rises;
      din = d; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0; din = ~d;
      lat = 0;
      first_mosi = 1'bx;
      while (!done && lat < 200) begin
         @(negedge clk);
         if (lat == 0) first_mosi = mosi;
         if (poke && lat == 20) begin start = 1'b1; din = 8'hFF; end
         if (poke && lat == 21) start = 1'b0;
         if (!done) lat++;
      end
      d_ss = ss_low - ss0; d_hi = sck_hi - hi0; d_rise = rises - r0;
   endtask

   initial begin
      int lat, d_ss, d_hi, d_rise, n, dones, first, last, busy_lo, ss_idle;
      logic fm;

      repeat (3) @(negedge clk);
      check("rst_ss", ss, 1'b1);
      check("rst_sck", sck, 1'b0);
      check("rst_mosi", mosi, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_dout", dout, 8'h00);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // loopback A5
      run_frame(8'hA5, 1'b0, lat, fm, d_ss, d_hi, d_rise);
      check("a5_lat", lat, 72);
      check("a5_dout", dout, 8'hA5);
      check("a5_mosi_bits", mosi_bits, 8'hA5);
      check("a5_rises", d_rise, 8);
      check("a5_ss_low", d_ss, 72);
      check("a5_sck_hi", d_hi, 32);
      check("a5_first_mosi", fm, 1'b1);
      check("a5_done_busy", busy, 1'b1);
      check("a5_done_ss", ss, 1'b1);
      @(negedge clk);
      check("a5_done_pulse", done, 1'b0);
      check("a5_busy_clr", busy, 1'b0);
      check("a5_mosi_idle", mosi, 1'b0);

      // start pulsed mid-frame with din=FF
      run_frame(8'h3C, 1'b1, lat, fm, d_ss, d_hi, d_rise);
      check("poke_lat", lat, 72);
      check("poke_dout", dout, 8'h3C);
      check("poke_mosi_bits", mosi_bits, 8'h3C);
      repeat (3) @(negedge clk);
      check("poke_no_queue", busy, 1'b0);

      // bit order
      run_frame(8'h01, 1'b0, lat, fm, d_ss, d_hi, d_rise);
      check("b01_dout", dout, 8'h01);
`ifdef SPI_MASTER_LSB_FIRST_EN
      check("b01_first_mosi", fm, 1'b1);
      check("b01_mosi_bits", mosi_bits, 8'h80);
`else
      check("b01_first_mosi", fm, 1'b0);
      check("b01_mosi_bits", mosi_bits, 8'h01);
`endif

      // against slave model
      loop = 1'b0; slave_din = 8'h3C;
      run_frame(8'hC3, 1'b0, lat, fm, d_ss, d_hi, d_rise);
      check("slv_lat", lat, 72);
      check("slv_master_dout", dout, 8'h3C);
      check("slv_slave_rx", s_rx, 8'hC3);
      loop = 1'b1;

      // start held for three frames
      @(negedge clk);
      din = 8'h5A; start = 1'b1;
      n = 0; dones = 0; first = 0; last = 0; busy_lo = 0; ss_idle = 0;
      while (dones < 3 && n < 400) begin
         @(negedge clk);
         n++;
         if (dones >= 1 && !busy) busy_lo++;
         if (dones >= 1 && ss && !busy) ss_idle++;
         if (done) begin
            dones++;
            if (dones == 1) first = n;
            if (dones == 3) last = n;
         end
      end
      start = 1'b0;
      check("held_dones", dones, 3);
      check("held_period", last - first, 148);
      check("held_busy_gaps", busy_lo, 2);
      check("held_ss_idle", ss_idle, 2);
      check("held_dout", dout, 8'h5A);
      repeat (4) @(negedge clk);
      check("held_stop", busy, 1'b0);

      // async reset mid-SHIFT
      @(negedge clk);
      din = 8'h96; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (21) @(negedge clk);
      check("mid_sck_high", sck, 1'b1);
      check("mid_busy", busy, 1'b1);
      #1 rst = 1'b0;
      #1;
      check("arst_ss", ss, 1'b1);
      check("arst_sck", sck, 1'b0);
      check("arst_mosi", mosi, 1'b0);
      check("arst_busy", busy, 1'b0);
      check("arst_done", done, 1'b0);
      check("arst_dout", dout, 8'h00);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (80) @(negedge clk);
      check("arst_no_resume", ss, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
